// File: rtl/reg_access_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of the PWM configuration register file.
// Define REG_ARB_BOOTLOAD_EN to load BOOT_VAL into every register after reset.
module reg_access_arbiter #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       NUM_REGS = 8,
  parameter logic [DATA_W-1:0] BOOT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

`ifdef REG_ARB_BOOTLOAD_EN
  typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, ACK, BOOT} stateT;
  localparam stateT RESET_STATE = BOOT;
  localparam logic  RESET_BUSY  = 1'b1;
  localparam int unsigned CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_REGS - 1);

  logic [CNT_W-1:0] bootCnt, bootCntNext;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} stateT;
  localparam stateT RESET_STATE = IDLE;
  localparam logic  RESET_BUSY  = 1'b0;

  // boot-load parameters have no consumer in this build
  logic unusedBootCfg;
  assign unusedBootCfg = ^{BOOT_VAL, NUM_REGS};
`endif

  stateT             state, stateNext;
  logic              lastGrantB, lastGrantBNext;
  logic              grantB, grantBNext;
  logic              pickB;
  logic              aAckNext, bAckNext;
  logic [DATA_W-1:0] aRdataNext, bRdataNext;
  logic [ADDR_W-1:0] regAddrNext;
  logic [DATA_W-1:0] regWdataNext;
  logic              regWeNext;
  logic              busyNext;

  // Contention goes to the port that did not win last time; a lone request always wins.
  assign pickB = b_req && (!a_req || !lastGrantB);

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RESET_STATE;
      lastGrantB <= 1'b1;
      grantB     <= 1'b0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_we     <= 1'b0;
      busy       <= RESET_BUSY;
`ifdef REG_ARB_BOOTLOAD_EN
      bootCnt    <= '0;
`endif
    end else begin
      state      <= stateNext;
      lastGrantB <= lastGrantBNext;
      grantB     <= grantBNext;
      a_ack      <= aAckNext;
      b_ack      <= bAckNext;
      a_rdata    <= aRdataNext;
      b_rdata    <= bRdataNext;
      reg_addr   <= regAddrNext;
      reg_wdata  <= regWdataNext;
      reg_we     <= regWeNext;
      busy       <= busyNext;
`ifdef REG_ARB_BOOTLOAD_EN
      bootCnt    <= bootCntNext;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    stateNext      = state;
    lastGrantBNext = lastGrantB;
    grantBNext     = grantB;
    aAckNext       = 1'b0;
    bAckNext       = 1'b0;
    aRdataNext     = a_rdata;
    bRdataNext     = b_rdata;
    regAddrNext    = reg_addr;
    regWdataNext   = reg_wdata;
    regWeNext      = 1'b0;
`ifdef REG_ARB_BOOTLOAD_EN
    bootCntNext    = bootCnt;
`endif
    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          grantBNext   = pickB;
          regAddrNext  = pickB ? b_addr  : a_addr;
          regWdataNext = pickB ? b_wdata : a_wdata;
          regWeNext    = pickB ? b_we    : a_we;
          if (a_req && b_req) begin
            lastGrantBNext = pickB;
          end
          stateNext = ACCESS;
        end
      end
      ACCESS: begin
        stateNext = CAPTURE;
      end
      CAPTURE: begin
        // File read path now holds the pre-write content of reg_addr.
        if (grantB) begin
          bRdataNext = reg_rdata;
          bAckNext   = 1'b1;
        end else begin
          aRdataNext = reg_rdata;
          aAckNext   = 1'b1;
        end
        stateNext = ACK;
      end
      ACK: begin
        stateNext = IDLE;
      end
`ifdef REG_ARB_BOOTLOAD_EN
      BOOT: begin
        regWeNext    = 1'b1;
        regAddrNext  = ADDR_W'(bootCnt);
        regWdataNext = BOOT_VAL;
        bootCntNext  = bootCnt + CNT_W'(1);
        if (bootCnt == LAST_IDX) begin
          stateNext = IDLE;
        end
      end
`endif
      default: begin
        stateNext = IDLE;
      end
    endcase
    busyNext = (stateNext != IDLE);
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter with a behavioural register file on the reg_* side.
// Also exercises the boot-load path when REG_ARB_BOOTLOAD_EN is defined.
`timescale 1ns/1ps
module tb_reg_access_arbiter;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned NUM_REGS = 8;
`ifdef REG_ARB_BOOTLOAD_EN
  localparam logic [7:0] BOOT_VAL = 8'hA5;
  localparam bit         BOOT_EN  = 1'b1;
`else
  localparam logic [7:0] BOOT_VAL = 8'h00;
  localparam bit         BOOT_EN  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_ack, b_ack;
  logic [7:0] a_rdata, b_rdata;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, busy;

  int vectors = 0;
  int miscompares = 0;

  reg_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .BOOT_VAL(BOOT_VAL)
  ) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file: write-enable, registered read of the old content, zero outside range.
  logic [7:0] mem [NUM_REGS];
  always @(posedge clk) begin
    if (reg_we && reg_addr < 8'(NUM_REGS)) mem[reg_addr[2:0]] <= reg_wdata;
    reg_rdata <= (reg_addr < 8'(NUM_REGS)) ? mem[reg_addr[2:0]] : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One single-port transaction, started in an IDLE cycle, ending in its ACK cycle.
  task automatic txn(input string tag, input bit useB, input bit we, input logic [7:0] addr,
                     input logic [7:0] wdata, input bit chkRd, input logic [7:0] expRd);
    logic [7:0] rd, wa;
    int lat, wc;
    bit oa;
    lat = 0; wc = 0; wa = 8'h00; oa = 1'b0; rd = 8'h00;
    @(negedge clk);
    if (useB) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; end
    else      begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (reg_we) begin wc++; wa = reg_addr; end
      if (useB ? b_ack : a_ack) begin
        lat = k;
        rd  = useB ? b_rdata : a_rdata;
        oa  = useB ? a_ack : b_ack;
        break;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check({tag, "/latency"}, 32'(lat), 32'd3);
    check({tag, "/we_pulses"}, 32'(wc), we ? 32'd1 : 32'd0);
    if (we) check({tag, "/we_addr"}, 32'(wa), 32'(addr));
    check({tag, "/other_ack"}, 32'(oa), 32'd0);
    if (chkRd) check({tag, "/rdata"}, 32'(rd), 32'(expRd));
  endtask

  // Hold reset two edges, release, and wait (bounded) until the block is idle.
  task automatic doReset(output bit ackSeen, output int waitCycles);
    rst = 1'b1;
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ackSeen = 1'b0;
    waitCycles = -1;
    for (int k = 0; k < 30; k++) begin
      if (a_ack || b_ack) ackSeen = 1'b1;
      if (!busy) begin waitCycles = k; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] snap [NUM_REGS];
    int ackPort [4];
    int ackTime [4];
    int ackData [4];
    int n, both, waitCyc;
    bit ackSeen;
    logic [7:0] expA, expB;

    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
    b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst/a_ack", 32'(a_ack), 32'd0);
    check("rst/b_ack", 32'(b_ack), 32'd0);
    check("rst/a_rdata", 32'(a_rdata), 32'd0);
    check("rst/b_rdata", 32'(b_rdata), 32'd0);
    check("rst/reg_addr", 32'(reg_addr), 32'd0);
    check("rst/reg_wdata", 32'(reg_wdata), 32'd0);
    check("rst/reg_we", 32'(reg_we), 32'd0);
    check("rst/busy", 32'(busy), 32'(BOOT_EN));

`ifdef REG_ARB_BOOTLOAD_EN
    begin
      int busyCnt, weCnt, ackC;
      bit busyEnded, weOk;
      logic [7:0] rd;
      busyCnt = 0; weCnt = 0; ackC = -1; busyEnded = 1'b0; weOk = 1'b1; rd = 8'h00;
      rst = 1'b0;
      a_req = 1'b1; a_we = 1'b0; a_addr = 8'h04;
      for (int c = 0; c < 16; c++) begin
        if (c > 0) @(negedge clk);
        if (busy && !busyEnded) busyCnt++;
        else busyEnded = 1'b1;
        if (reg_we && ackC < 0) begin
          if (reg_addr != 8'(weCnt) || reg_wdata != BOOT_VAL) weOk = 1'b0;
          weCnt++;
        end
        if (a_ack && ackC < 0) begin ackC = c; rd = a_rdata; a_req = 1'b0; end
      end
      a_req = 1'b0;
      check("boot/busy_cycles", 32'(busyCnt), 32'd8);
      check("boot/we_cycles", 32'(weCnt), 32'd8);
      check("boot/we_addr_data", 32'(weOk), 32'd1);
      check("boot/req_ack_cycle", 32'(ackC), 32'd11);
      check("boot/req_rdata", 32'(rd), 32'hA5);
    end
    txn("boot_read0", 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hA5);
`else
    rst = 1'b0;
`endif

    // Basic write/read and read-before-write.
    txn("a_wr3", 1'b0, 1'b1, 8'h03, 8'h5A, BOOT_EN, BOOT_VAL);
    txn("a_wr2", 1'b0, 1'b1, 8'h02, 8'h11, BOOT_EN, BOOT_VAL);
    txn("a_rd3", 1'b0, 1'b0, 8'h03, 8'h00, 1'b1, 8'h5A);
    check("b_rdata_idle_hold", 32'(b_rdata), 32'd0);
    txn("b_wr2_rbw", 1'b1, 1'b1, 8'h02, 8'h22, 1'b1, 8'h11);
    check("a_rdata_hold1", 32'(a_rdata), 32'h5A);
    txn("b_rd2", 1'b1, 1'b0, 8'h02, 8'h00, 1'b1, 8'h22);
    check("a_rdata_hold2", 32'(a_rdata), 32'h5A);

    // Out-of-range addresses pass through; the file ignores them.
    for (int i = 0; i < int'(NUM_REGS); i++) snap[i] = mem[i];
    txn("a_rd9", 1'b0, 1'b0, 8'h09, 8'h00, 1'b1, 8'h00);
    txn("b_wr9", 1'b1, 1'b1, 8'h09, 8'hFF, 1'b1, 8'h00);
    for (int i = 0; i < int'(NUM_REGS); i++)
      check($sformatf("oor_keep%0d", i), 32'(mem[i]), 32'(snap[i]));
    txn("a_rd2_after_oor", 1'b0, 1'b0, 8'h02, 8'h00, 1'b1, 8'h22);

    // Contention straight after reset: A first, then strict alternation.
    doReset(ackSeen, waitCyc);
    expA = BOOT_EN ? BOOT_VAL : 8'h5A;
    expB = BOOT_EN ? BOOT_VAL : 8'h22;
    for (int i = 0; i < 4; i++) begin ackPort[i] = -1; ackTime[i] = -1; ackData[i] = -1; end
    n = 0; both = 0;
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h03;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h02;
    for (int k = 1; k <= 40 && n < 4; k++) begin
      @(negedge clk);
      if (a_ack && b_ack) both++;
      if (a_ack || b_ack) begin
        ackPort[n] = b_ack ? 1 : 0;
        ackTime[n] = k;
        ackData[n] = int'(b_ack ? b_rdata : a_rdata);
        n++;
        if (n == 4) begin a_req = 1'b0; b_req = 1'b0; end
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    check("cont/ack_count", 32'(n), 32'd4);
    check("cont/simultaneous", 32'(both), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cont/port%0d", i), 32'(ackPort[i]), 32'(i % 2));
      check($sformatf("cont/time%0d", i), 32'(ackTime[i]), 32'(3 + 4 * i));
      check($sformatf("cont/data%0d", i), 32'(ackData[i]), (i % 2 == 1) ? 32'(expB) : 32'(expA));
    end

    // Reset during the ACCESS cycle of a write.
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h05; a_wdata = 8'h77;
    @(negedge clk);
    check("midrst/access_we", 32'(reg_we), 32'd1);
    check("midrst/access_addr", 32'(reg_addr), 32'h05);
    #1 rst = 1'b1;
    #1;
    check("midrst/we_drop", 32'(reg_we), 32'd0);
    check("midrst/busy", 32'(busy), 32'(BOOT_EN));
    check("midrst/no_ack", 32'(a_ack), 32'd0);
    doReset(ackSeen, waitCyc);
    check("midrst/ack_after", 32'(ackSeen), 32'd0);
    check("midrst/idle_wait", 32'(waitCyc), BOOT_EN ? 32'd8 : 32'd0);
    txn("reissue_wr5", 1'b0, 1'b1, 8'h05, 8'h77, BOOT_EN, BOOT_VAL);
    txn("reissue_rd5", 1'b0, 1'b0, 8'h05, 8'h00, 1'b1, 8'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
Two-port arbiter and sequencer in front of the 8-entry PWM configuration register file. Port A serves the I2C slave; port B serves a local requester (PWM status/update logic or test host). The block grants one port at a time using round-robin. It drives the register file's address, write data and write-enable, and returns the read data from the file's one-cycle registered read path, with a req/ack handshake.

Parameters:
ADDR_W, 8, register address width
DATA_W, 8, register data width
NUM_REGS, 8, number of implemented registers (boot-load range)
BOOT_VAL, 8'h00, value written to every register during boot load

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
a_req  input  1  port A request; held high until a_ack
a_we  input  1  port A write (1) / read (0); stable while a_req
a_addr  input  ADDR_W  port A register address
a_wdata  input  DATA_W  port A write data
a_ack  output  1  port A one-cycle completion pulse
a_rdata  output  DATA_W  port A read data; valid when a_ack
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as port A, for port B
reg_addr  output  ADDR_W  to register file address
reg_wdata  output  DATA_W  to register file dataIn
reg_we  output  1  to register file writeEn
reg_rdata  input  DATA_W  from register file dataOut (registered, 1-cycle latency)
busy  output  1  high whenever state != IDLE

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst). All outputs are registered.
- Reset values: a_ack=b_ack=0, a_rdata=b_rdata=0, reg_addr=0, reg_wdata=0, reg_we=0, busy=0 (busy=1 if boot load is enabled). State=IDLE (or BOOT). last_grant=B.
- FSM states: IDLE -> ACCESS -> CAPTURE -> ACK -> IDLE.
- IDLE: sample a_req/b_req.
  - If only one is high, grant that port.
  - If both are high, grant the port not equal to last_grant, then update last_grant.
  - On grant, latch we/addr/wdata into reg_we/reg_addr/reg_wdata and go to ACCESS.
- ACCESS (1 cycle): reg_addr/reg_wdata/reg_we are presented to the file. At the end of the cycle the file writes (if reg_we) and loads dataOut with the old content. Next state is CAPTURE. reg_we is cleared on leaving ACCESS.
- CAPTURE (1 cycle): reg_rdata is valid. The granted port's rdata is loaded from reg_rdata, and that port's ack is set for the next cycle. Next state is ACK.
- ACK (1 cycle): the granted ack is high and all other acks are low. Requests are ignored in this state. Next state is IDLE.
- Latency: req seen in IDLE at cycle N -> ack high in cycle N+3. Throughput: one transaction per 4 cycles; back-to-back requests are allowed.
- Writes return read-before-write data in rdata (the register value prior to the write).
- The non-granted port's rdata holds its previous value.
- reg_we is high for exactly one cycle per write and never high on reads.
- Addresses >= NUM_REGS are passed through unchanged. The file returns 0 for such reads and ignores such writes. The arbiter does not filter them.
- A requester dropping req before ack is a protocol violation. The transaction still completes and the ack is still pulsed.
- If rst is asserted mid-transaction: the FSM returns to reset state immediately and reg_we drops asynchronously. The in-flight transaction is lost and no ack is issued. Requesters re-issue after reset.
- last_grant is updated only when both ports contend.

Optional Feature:
Macro REG_ARB_BOOTLOAD_EN.
- Enabled: after rst deasserts, the FSM starts in BOOT.
  - BOOT writes BOOT_VAL to addresses 0..NUM_REGS-1, one per cycle, with reg_we=1 and an incrementing counter.
  - After the last address it goes to IDLE. BOOT lasts NUM_REGS cycles.
  - busy=1 throughout BOOT. Requests raised during BOOT wait, then follow the normal arbitration.
- Disabled: the BOOT state and counter are absent, and reset enters IDLE directly. Register contents are undefined until written.

Test Plan:
- A write then A read:
  - Write: a_req, we=1, addr=3, wdata=8'h5A -> reg_we high for 1 cycle with reg_addr=3; a_ack 3 cycles after request.
  - Read: read addr 3 -> a_rdata=8'h5A with a_ack.
- Read-before-write: reg 2=8'h11; B writes 8'h22 to addr 2 -> b_rdata=8'h11 at b_ack; a later read returns 8'h22.
- Contention: a_req and b_req both raised in the same cycle after reset, repeatedly -> grants alternate A, B, A, B; each ack is 4 cycles apart; no simultaneous acks.
- Out-of-range: read addr 8'h09 -> rdata=8'h00, ack after 3 cycles. Write to 8'h09 -> registers 0..7 unchanged.
- Reset mid-op: assert rst during ACCESS of a write -> no ack, reg_we low immediately, busy low (or BOOT restarts); a re-issued request completes normally.
- With REG_ARB_BOOTLOAD_EN, BOOT_VAL=8'hA5:
  - After reset, busy high 8 cycles; reg_we high with reg_addr 0..7.
  - A read of any register returns 8'hA5.
  - An a_req raised during BOOT is acked 3 cycles after boot ends.
